// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/clear bus of the multi-read-port register file
interface regfile_mp_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
) ();
  localparam int AW  = $clog2(DEPTH);
  localparam int NBE = WIDTH / 8;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [NBE-1:0]          wr_be;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic                    clr_req;
  logic                    busy;
  logic                    wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr, clr_req,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr, clr_req,
    output rd_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file with byte writes, registered reads and clear engine
module regfile_mp #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = DEPTH - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         VDD,
  inout  wire         VSS,
  regfile_mp_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NBE = WIDTH / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    clr_ptr, clr_ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_old, wr_merged;
  logic             busy, wr_ok, rd_blank, wr_drop_q;
  logic             unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic addr_zero(input logic [AW-1:0] a);
    return (ZERO_EN != 0) && (int'(a) == ZERO_IDX);
  endfunction

  assign busy  = (state == S_CLEAR);
  assign wr_ok = bus.wr_en && !busy && addr_valid(bus.wr_addr) && !addr_zero(bus.wr_addr);
  // Reads sampled while clearing (or on the cycle a clear starts) return zero.
  assign rd_blank = busy || (state_nxt == S_CLEAR);

  assign wr_old = addr_valid(bus.wr_addr) ? mem[bus.wr_addr] : '0;

  always_comb begin
    wr_merged = wr_old;
    for (int b = 0; b < NBE; b++) begin
      if (bus.wr_be[b]) wr_merged[b*8 +: 8] = bus.wr_data[b*8 +: 8];
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_nxt   = S_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (int'(clr_ptr) == DEPTH - 1) begin
          state_nxt   = S_IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + AW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clr_ptr   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_ptr   <= clr_ptr_nxt;
      wr_drop_q <= bus.wr_en && !wr_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] q;

    assign addr = bus.rd_addr[p*AW +: AW];

    always_comb begin
      val = '0;
      if (addr_valid(addr) && !addr_zero(addr)) val = mem[addr];
      if ((BYPASS != 0) && wr_ok && (bus.wr_addr == addr)) val = wr_merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= rd_blank ? '0 : val;
    end

    assign bus.rd_data[p*WIDTH +: WIDTH] = q;
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table- and scoreboard-driven bench for regfile_mp
module tb_regfile_mp;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  wire  vdd, vss;
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(16), .DEPTH(16), .NUM_RD(2)) bus_a ();
  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(4)) bus_b ();

  regfile_mp #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .VDD(vdd), .VSS(vss), .bus(bus_a)
  );
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .VDD(vdd), .VSS(vss), .bus(bus_b)
  );

  typedef struct {
    bit           sel_b;
    bit           chk_rd;
    logic [127:0] rd;
    logic         drop;
    logic         busy;
  } exp_t;

  typedef struct {
    bit          we;
    int          wa;
    logic [15:0] wd;
    logic [1:0]  be;
    int          r0;
    int          r1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        edrop;
  } vec_t;

  exp_t sbq[$];

  function automatic logic [15:0] fillv(input int i);
    return (i < 0 || i >= 15) ? 16'h0000 : 16'(i * 32'h2408);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, stepn, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    stepn++;
    e = sbq.pop_front();
    if (!e.sel_b) begin
      if (e.chk_rd) chk("a_rd", 128'(bus_a.rd_data), e.rd);
      chk("a_drop", 128'(bus_a.wr_drop), 128'(e.drop));
      chk("a_busy", 128'(bus_a.busy), 128'(e.busy));
    end else begin
      if (e.chk_rd) chk("b_rd", bus_b.rd_data, e.rd);
      chk("b_drop", 128'(bus_b.wr_drop), 128'(e.drop));
      chk("b_busy", 128'(bus_b.busy), 128'(e.busy));
    end
  endtask

  task automatic cyc_a(input bit we, input int wa, input logic [15:0] wd, input logic [1:0] be,
                       input int r0, input int r1, input bit clr, input bit chk_rd,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic edrop, input logic ebusy);
    bus_a.wr_en   = we;
    bus_a.wr_addr = 4'(wa);
    bus_a.wr_data = wd;
    bus_a.wr_be   = be;
    bus_a.rd_addr = {4'(r1), 4'(r0)};
    bus_a.clr_req = clr;
    sbq.push_back('{1'b0, chk_rd, {96'h0, e1, e0}, edrop, ebusy});
    step();
  endtask

  task automatic cyc_b(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                       input int r0, input int r1, input int r2, input int r3,
                       input logic [127:0] erd, input logic edrop);
    bus_b.wr_en   = we;
    bus_b.wr_addr = 5'(wa);
    bus_b.wr_data = wd;
    bus_b.wr_be   = be;
    bus_b.rd_addr = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    bus_b.clr_req = 1'b0;
    sbq.push_back('{1'b1, 1'b1, erd, edrop, 1'b0});
    step();
  endtask

  initial begin
    vec_t vecs[$];

    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_be = '0;
    bus_a.rd_addr = '0; bus_a.clr_req = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_be = '0;
    bus_b.rd_addr = '0; bus_b.clr_req = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_rd", 128'(bus_a.rd_data), 128'h0);
    chk("rst_a_busy", 128'(bus_a.busy), 128'h0);
    chk("rst_a_drop", 128'(bus_a.wr_drop), 128'h0);
    chk("rst_b_rd", bus_b.rd_data, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset readback, fill with simultaneous reads, zero-register write, full readback.
    for (int j = 0; j < 8; j++)
      vecs.push_back('{1'b0, 0, 16'h0, 2'b00, 2*j, 2*j+1, 16'h0, 16'h0, 1'b0});
    for (int i = 0; i < 15; i++)
      vecs.push_back('{1'b1, i, fillv(i), 2'b11, (i == 0) ? 15 : i-1, i, fillv(i-1), fillv(i), 1'b0});
    vecs.push_back('{1'b1, 15, 16'h00A0, 2'b11, 15, 14, 16'h0, fillv(14), 1'b1});
    for (int j = 0; j < 8; j++)
      vecs.push_back('{1'b0, 0, 16'h0, 2'b00, 2*j, 2*j+1, fillv(2*j), fillv(2*j+1), 1'b0});

    foreach (vecs[k])
      cyc_a(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].be, vecs[k].r0, vecs[k].r1, 1'b0, 1'b1,
            vecs[k].e0, vecs[k].e1, vecs[k].edrop, 1'b0);

    // Byte-enabled write with bypass, then a be=0 no-op write.
    cyc_a(1'b1, 3, 16'h1234, 2'b11, 0, 0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    cyc_a(1'b1, 3, 16'hABCD, 2'b01, 3, 3, 1'b0, 1'b1, 16'h12CD, 16'h12CD, 1'b0, 1'b0);
    cyc_a(1'b1, 4, 16'hFFFF, 2'b00, 3, 4, 1'b0, 1'b1, 16'h12CD, 16'h9020, 1'b0, 1'b0);
    cyc_a(1'b0, 0, 16'h0, 2'b00, 4, 3, 1'b0, 1'b1, 16'h9020, 16'h12CD, 1'b0, 1'b0);

    // Wide instance without bypass: four distinct ports, zero register, pre-write read value.
    cyc_b(1'b1, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 128'h0, 1'b0);
    cyc_b(1'b1, 7, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 128'h0, 1'b0);
    cyc_b(1'b1, 20, 32'h13579BDF, 4'hF, 0, 0, 0, 0, 128'h0, 1'b0);
    cyc_b(1'b1, 30, 32'h2468ACE0, 4'hF, 0, 0, 0, 0, 128'h0, 1'b0);
    cyc_b(1'b0, 0, 32'h0, 4'h0, 1, 7, 20, 30, {32'h2468ACE0, 32'h13579BDF, 32'h0BADF00D, 32'hDEADBEEF}, 1'b0);
    cyc_b(1'b1, 31, 32'hFFFFFFFF, 4'hF, 31, 31, 31, 31, 128'h0, 1'b1);
    cyc_b(1'b0, 0, 32'h0, 4'h0, 31, 31, 31, 31, 128'h0, 1'b0);
    cyc_b(1'b1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0, 128'h0, 1'b0);
    cyc_b(1'b1, 3, 32'hAABBCCDD, 4'b0101, 3, 3, 3, 3, {4{32'h11223344}}, 1'b0);
    cyc_b(1'b0, 0, 32'h0, 4'h0, 3, 3, 3, 3, {4{32'h11BB33DD}}, 1'b0);
    cyc_b(1'b0, 0, 32'h0, 4'h0, 30, 20, 7, 1, {32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0}, 1'b0);

    // Clear with a write in the start cycle, a dropped write and an ignored clr_req while busy.
    cyc_a(1'b1, 5, 16'hFFFF, 2'b11, 1, 2, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 1; k < 16; k++)
      cyc_a(k == 3, 6, 16'h5A5A, 2'b11, 1, 2, k == 8, 1'b1, 16'h0, 16'h0, k == 3, 1'b1);
    cyc_a(1'b0, 0, 16'h0, 2'b00, 0, 1, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++)
      cyc_a(1'b0, 0, 16'h0, 2'b00, 2*j, 2*j+1, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset while rd_data holds a nonzero value.
    cyc_a(1'b1, 2, 16'h5555, 2'b11, 2, 2, 1'b0, 1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_rst_rd", 128'(bus_a.rd_data), 128'h0);
    chk("async_rst_busy", 128'(bus_a.busy), 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 8; j++)
      cyc_a(1'b0, 0, 16'h0, 2'b00, 2*j, 2*j+1, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset during the fifth cycle of a clear aborts it.
    cyc_a(1'b0, 0, 16'h0, 2'b00, 0, 1, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 1; k < 5; k++)
      cyc_a(1'b0, 0, 16'h0, 2'b00, 0, 1, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("clr_rst_busy", 128'(bus_a.busy), 128'h0);
    chk("clr_rst_rd", 128'(bus_a.rd_data), 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_a(1'b1, 1, 16'h0F0F, 2'b11, 1, 15, 1'b0, 1'b1, 16'h0F0F, 16'h0, 1'b0, 1'b0);
    cyc_a(1'b0, 0, 16'h0, 2'b00, 1, 0, 1'b0, 1'b1, 16'h0F0F, 16'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
